// File: rtl/sample_logger_avmm_master_pkg.sv
// Shared types for the sample logger: FSM state encoding and Avalon byte-enable patterns.
package logger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_LO   = 4'h3;

endpackage

// File: rtl/sample_logger_avmm_master_if.sv
// Avalon-MM write port toward the on-chip log RAM, plus the arbiter's stall line.
interface sample_logger_avmm_master_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic              mem_stall;

  modport master (
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_stall
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_stall
  );
endinterface

// File: rtl/sample_logger_avmm_master_packer.sv
// Packs 16-bit samples two per 32-bit word; word_valid pulses with the odd sample's accept.
module sample_packer_16to32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic        flush_take,
  input  logic [15:0] data,
  output logic        half_held,
  output logic        half_next,
  output logic        word_valid,
  output logic [15:0] lo,
  output logic [31:0] word
);

  assign word_valid = accept & half_held;
  assign word       = {data, lo};
  assign half_next  = half_held ^ accept;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      half_held <= 1'b0;
      lo        <= '0;
    end else if (flush_take) begin
      half_held <= 1'b0;
    end else if (accept) begin
      half_held <= ~half_held;
      if (!half_held) lo <= data;
    end
  end

endmodule

// File: rtl/sample_logger_avmm_master.sv
// Sample logger: packs 16-bit samples into 32-bit words and writes them to a RAM region over Avalon-MM.
module sample_logger_avmm_master
  import logger_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int BASE_WORD   = 0,
  parameter int DEPTH_WORDS = 12000,
  parameter int ONESHOT     = 0,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        sample_valid,
  input  logic [15:0]                 sample_data,
  output logic                        sample_ready,
  sample_logger_avmm_master_if.master mem,
  output logic [ADDR_W-1:0]           wr_ptr,
  output logic                        wrapped,
  output logic                        full,
  output logic                        busy,
  output logic [CNT_W-1:0]            drop_count
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_WORD);

  state_t      state;
  logic        wr_q, clken_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;

  logic        accept, done_wr, at_last, go, flush_load;
  logic        half_held, half_next, word_valid;
  logic [15:0] lo;
  logic [31:0] word;

  assign sample_ready = (state == CAPTURE) & ~(wr_q & mem.mem_stall);
  assign accept       = sample_valid & sample_ready;
  assign done_wr      = wr_q & ~mem.mem_stall;
  assign at_last      = (wr_ptr == LAST);
  // A write still draining after stop owns the address, so IDLE waits for it before restarting.
  assign go           = start & (((state == IDLE) & ~wr_q) | (state == DONE));
  assign flush_load   = (state == FLUSH) & half_held & ~wr_q;

  sample_packer_16to32 u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (go),
    .accept     (accept),
    .flush_take (flush_load),
    .data       (sample_data),
    .half_held  (half_held),
    .half_next  (half_next),
    .word_valid (word_valid),
    .lo         (lo),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if ((ONESHOT != 0) && done_wr && at_last) begin
      state <= DONE;
    end else begin
      case (state)
        IDLE:    if (go) state <= CAPTURE;
        CAPTURE: if (stop) state <= half_next ? FLUSH : IDLE;
        FLUSH:   if (done_wr && !half_held) state <= IDLE;
        DONE:    if (go) state <= CAPTURE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write slot: loaded one cycle after the odd sample, held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= 1'b0;
      data_q <= '0;
      be_q   <= BE_FULL;
    end else if (word_valid) begin
      wr_q   <= 1'b1;
      data_q <= word;
      be_q   <= BE_FULL;
    end else if (flush_load) begin
      wr_q   <= 1'b1;
      data_q <= {16'h0000, lo};
      be_q   <= BE_LO;
    end else if (done_wr) begin
      wr_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || go) begin
      wr_ptr  <= '0;
      wrapped <= 1'b0;
      full    <= 1'b0;
    end else if (done_wr) begin
      if (!at_last) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end else if (ONESHOT != 0) begin
        full <= 1'b1;
      end else begin
        wr_ptr  <= '0;
        wrapped <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || go)
      drop_count <= '0;
    else if ((state == CAPTURE) && sample_valid && !sample_ready && !(&drop_count))
      drop_count <= drop_count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) clken_q <= 1'b0;
    else       clken_q <= 1'b1;
  end

  assign busy = (state != IDLE);

  // Gating with reset keeps an abandoned write from reaching the RAM in the reset cycle.
  assign mem.mem_write      = wr_q & ~reset;
  assign mem.mem_chipselect = wr_q & ~reset;
  assign mem.mem_address    = BASE + wr_ptr;
  assign mem.mem_writedata  = data_q;
  assign mem.mem_byteenable = be_q;
  assign mem.mem_clken      = clken_q;

endmodule

// File: tb/tb_sample_logger_avmm_master.sv
// Bench: a small circular logger and a one-shot logger driven by shared stimulus.
module tb_sample_logger_avmm_master;

  localparam int AW = 14;
  localparam int CB = 0;
  localparam int CD = 4;
  localparam int OB = 6;
  localparam int OD = 2;

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, stop = 1'b0, valid = 1'b0;
  logic [15:0] data = '0;
  logic        stall_c = 1'b0, stall_o = 1'b0;

  logic        ready_c, ready_o, wrap_c, wrap_o, full_c, full_o, busy_c, busy_o;
  logic [13:0] ptr_c, ptr_o;
  logic [2:0]  drop_c;
  logic [15:0] drop_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] acc_c[$], acc_o[$];
  wr_t         wr_c[$], wr_o[$];

  sample_logger_avmm_master_if #(.ADDR_W(AW)) if_c ();
  sample_logger_avmm_master_if #(.ADDR_W(AW)) if_o ();
  assign if_c.mem_stall = stall_c;
  assign if_o.mem_stall = stall_o;

  always #5 clk = ~clk;

  sample_logger_avmm_master #(
    .ADDR_W(AW), .BASE_WORD(CB), .DEPTH_WORDS(CD), .ONESHOT(0), .CNT_W(3)
  ) u_circ (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .sample_valid(valid), .sample_data(data), .sample_ready(ready_c),
    .mem(if_c), .wr_ptr(ptr_c), .wrapped(wrap_c), .full(full_c),
    .busy(busy_c), .drop_count(drop_c)
  );

  sample_logger_avmm_master #(
    .ADDR_W(AW), .BASE_WORD(OB), .DEPTH_WORDS(OD), .ONESHOT(1), .CNT_W(16)
  ) u_once (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .sample_valid(valid), .sample_data(data), .sample_ready(ready_o),
    .mem(if_o), .wr_ptr(ptr_o), .wrapped(wrap_o), .full(full_o),
    .busy(busy_o), .drop_count(drop_o)
  );

  // Bus monitor: log accepted samples and completed writes.
  always @(negedge clk) begin
    if (!reset && valid && ready_c) acc_c.push_back(data);
    if (!reset && valid && ready_o) acc_o.push_back(data);
    if (if_c.mem_write && !if_c.mem_stall)
      wr_c.push_back(wr_t'({if_c.mem_address, if_c.mem_writedata, if_c.mem_byteenable}));
    if (if_o.mem_write && !if_o.mem_stall)
      wr_o.push_back(wr_t'({if_o.mem_address, if_o.mem_writedata, if_o.mem_byteenable}));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: pair accepted samples into words, lay them out from the region base,
  // wrap (circular) or cap at the region size (one-shot), then add a half-word flush.
  task automatic check_log(input string tag, input bit osh, input bit flush);
    logic [15:0] s[$];
    wr_t w[$];
    wr_t e[$];
    int base, depth, n;
    if (osh) begin
      s = acc_o; w = wr_o; base = OB; depth = OD;
      acc_o.delete(); wr_o.delete();
    end else begin
      s = acc_c; w = wr_c; base = CB; depth = CD;
      acc_c.delete(); wr_c.delete();
    end
    n = 0;
    for (int i = 0; i + 1 < s.size(); i += 2) begin
      if (osh && n == depth) break;
      e.push_back(wr_t'({14'(base + n % depth), s[i+1], s[i], 4'hF}));
      n++;
    end
    if (flush && (s.size() % 2 == 1) && !(osh && n == depth))
      e.push_back(wr_t'({14'(base + n % depth), 16'h0000, s[s.size()-1], 4'h3}));
    chk({tag, "_cnt"}, 64'(w.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < w.size(); i++)
      chk(tag, 64'(w[i]), 64'(e[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b, c, x, y, z;
    int issued;

    // reset state
    step(2);
    chk("rst_c_bus", {if_c.mem_address, if_c.mem_write, if_c.mem_chipselect, if_c.mem_writedata,
                      if_c.mem_byteenable, if_c.mem_clken},
                     {14'd0, 1'b0, 1'b0, 32'd0, 4'hF, 1'b0});
    chk("rst_c_stat", {ptr_c, wrap_c, full_c, busy_c, drop_c, ready_c},
                      {14'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    chk("rst_o_addr", {if_o.mem_address, if_o.mem_write, full_o, busy_o}, {14'(OB), 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    step(1);
    chk("clken", {if_c.mem_clken, if_o.mem_clken}, 2'b11);

    // 1: one packed word
    start = 1'b1; step(1); start = 1'b0;
    chk("t1_busy", {busy_c, busy_o, ready_c}, 3'b111);
    valid = 1'b1; data = 16'h1111; step(1);
    data = 16'h2222; step(1); valid = 1'b0;
    chk("t1_wr_c", {if_c.mem_write, if_c.mem_chipselect, if_c.mem_address, if_c.mem_writedata,
                    if_c.mem_byteenable}, {2'b11, 14'd0, 32'h22221111, 4'hF});
    chk("t1_addr_o", if_o.mem_address, 14'(OB));
    step(1);
    chk("t1_done", {if_c.mem_write, ptr_c, ptr_o}, {1'b0, 14'd1, 14'd1});
    check_log("t1_c", 1'b0, 1'b0);
    check_log("t1_o", 1'b1, 1'b0);

    // 2/3: ten samples -> circular wrap, one-shot fills and parks
    stop = 1'b1; step(1); stop = 1'b0;
    chk("t2_idle", {busy_c, busy_o}, 2'b00);
    start = 1'b1; step(1); start = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = 16'($urandom);
      step(1);
      if (i == 6) chk("t2_mid", {wrap_c, ptr_c}, {1'b0, 14'd3});
      if (i == 8) chk("t2_wrap", {wrap_c, ptr_c}, {1'b1, 14'd0});
    end
    valid = 1'b0;
    step(1);
    chk("t2_end_c", {wrap_c, ptr_c, busy_c}, {1'b1, 14'd1, 1'b1});
    chk("t3_o", {full_o, busy_o, ready_o, drop_o, ptr_o, wrap_o},
                {1'b1, 1'b1, 1'b0, 16'd0, 14'd1, 1'b0});
    check_log("t2_c", 1'b0, 1'b0);
    check_log("t3_o", 1'b1, 1'b0);

    // 4: three samples, stop with the last -> full word then half-word flush
    stop = 1'b1; step(1); stop = 1'b0;
    chk("t4_pre", {busy_c, busy_o}, 2'b01);
    start = 1'b1; step(1); start = 1'b0;
    chk("t4_restart", {busy_o, full_o, ptr_o, drop_o}, {1'b1, 1'b0, 14'd0, 16'd0});
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    valid = 1'b1; data = a; step(1);
    data = b; step(1);
    data = c; stop = 1'b1; step(1);
    valid = 1'b0; stop = 1'b0;
    chk("t4_flush_st", {busy_c, if_c.mem_write}, 2'b10);
    step(1);
    chk("t4_fl_wr", {if_c.mem_write, if_c.mem_byteenable, if_c.mem_writedata, if_c.mem_address},
                    {1'b1, 4'h3, 16'h0000, c, 14'd1});
    step(1);
    chk("t4_end", {busy_c, ptr_c, busy_o, full_o}, {1'b0, 14'd2, 1'b1, 1'b1});
    check_log("t4_c", 1'b0, 1'b1);
    check_log("t4_o", 1'b1, 1'b1);

    // 5: stall with a write pending while valid is held; drops saturate at 7
    start = 1'b1; step(1); start = 1'b0;
    x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
    valid = 1'b1; data = x; step(1);
    data = y; step(1);
    data = z; stall_c = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("t5_hold", {if_c.mem_write, if_c.mem_address, if_c.mem_writedata, if_c.mem_byteenable, ready_c},
                     {1'b1, 14'd0, y, x, 4'hF, 1'b0});
      step(1);
      if (i == 4) chk("t5_drop5", {drop_c, ptr_c}, {3'd5, 14'd0});
    end
    chk("t5_drop_sat", {drop_c, ptr_c}, {3'd7, 14'd0});
    stall_c = 1'b0;
    step(1);
    valid = 1'b0;
    chk("t5_release", {ptr_c, drop_c}, {14'd1, 3'd7});
    stop = 1'b1; step(1); stop = 1'b0;
    for (int k = 0; k < 20 && busy_c; k++) step(1);
    chk("t5_idle", busy_c, 1'b0);
    check_log("t5_c", 1'b0, 1'b1);
    check_log("t5_o", 1'b1, 1'b1);

    // 6: reset the cycle after the odd sample
    start = 1'b1; step(1); start = 1'b0;
    valid = 1'b1; data = 16'($urandom); step(1);
    data = 16'($urandom); step(1);
    valid = 1'b0; reset = 1'b1;
    #1;
    chk("t6_gate", {if_c.mem_write, if_o.mem_write}, 2'b00);
    step(1);
    chk("t6_rst_c", {if_c.mem_address, if_c.mem_write, if_c.mem_chipselect, if_c.mem_writedata,
                     if_c.mem_byteenable, ptr_c, wrap_c, full_c, busy_c, drop_c, ready_c},
                    {14'd0, 1'b0, 1'b0, 32'd0, 4'hF, 14'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    chk("t6_rst_o", {if_o.mem_address, if_o.mem_write, ptr_o, full_o, busy_o, drop_o},
                    {14'(OB), 1'b0, 14'd0, 1'b0, 1'b0, 16'd0});
    chk("t6_nowr", 64'(wr_c.size() + wr_o.size()), 64'd0);
    acc_c.delete(); acc_o.delete();
    reset = 1'b0;
    step(2);

    // 7: random traffic with random stalls
    start = 1'b1; step(1); start = 1'b0;
    issued = 0;
    for (int i = 0; i < 60; i++) begin
      valid   = 1'($urandom_range(0, 1));
      data    = 16'($urandom);
      stall_c = ($urandom_range(0, 9) < 3);
      if (valid) issued++;
      step(1);
    end
    valid = 1'b0; stall_c = 1'b0;
    chk("t7_drop", 64'(drop_c),
        64'(((issued - acc_c.size()) > 7) ? 7 : (issued - acc_c.size())));
    stop = 1'b1; step(1); stop = 1'b0;
    for (int k = 0; k < 30 && (busy_c || (busy_o && !full_o)); k++) step(1);
    chk("t7_idle", {busy_c, busy_o && !full_o}, 2'b00);
    check_log("t7_c", 1'b0, 1'b1);
    check_log("t7_o", 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
